// File: rtl/mul_mux_datapath_if.sv
// Operand/product bundle between the ALU input stage and the mul/mux datapath.
// Latency: none of its own; the combinational outputs follow the inputs, MulReg lags by one edge.
// Backpressure: none; every signal is sampled or driven on every cycle.
interface mul_mux_datapath_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]   mux_a;
  logic [WIDTH-1:0]   mux_b;
  logic               sel;
  logic [WIDTH-1:0]   mux_out;
  logic [WIDTH-1:0]   gate_in;
  logic               en;
  logic [WIDTH-1:0]   gate_out;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic [WIDTH-1:0]   mul_out;
  logic [2*WIDTH-1:0] mul_full;
  logic               we;
  logic [2*WIDTH-1:0] mul_reg;

  // Driver side: supplies operands and controls, observes results.
  modport master (
    output mux_a, mux_b, sel, gate_in, en, mul_a, mul_b, we,
    input  mux_out, gate_out, mul_out, mul_full, mul_reg
  );

  // Datapath side: consumes operands and controls, produces results.
  modport slave (
    input  mux_a, mux_b, sel, gate_in, en, mul_a, mul_b, we,
    output mux_out, gate_out, mul_out, mul_full, mul_reg
  );
endinterface

// File: rtl/mul_mux_datapath.sv
// picoMips ALU operand primitives: 2:1 select mux, enable-gated zero mux, signed multiplier and product register.
// Latency: mux, gate and product outputs are combinational; MulReg updates one rising edge after its inputs.
// Backpressure: none; WE gates the product register load, reset has priority over WE.
module mul_mux_datapath #(
  parameter int WIDTH = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  mul_mux_datapath_if.slave io_bus
);

  // Sign-extended operands so the product is formed at full width and never overflows.
  logic signed [2*WIDTH-1:0] w_mul_a_ext;
  logic signed [2*WIDTH-1:0] w_mul_b_ext;
  logic signed [2*WIDTH-1:0] w_mul_full;
  logic        [2*WIDTH-1:0] r_mul_reg;

  assign w_mul_a_ext = {{WIDTH{io_bus.mul_a[WIDTH-1]}}, io_bus.mul_a};
  assign w_mul_b_ext = {{WIDTH{io_bus.mul_b[WIDTH-1]}}, io_bus.mul_b};

  // Single-cycle signed multiply; the low 2*WIDTH bits of the extended product are exact.
  assign w_mul_full = w_mul_a_ext * w_mul_b_ext;

  assign io_bus.mux_out  = io_bus.sel ? io_bus.mux_a : io_bus.mux_b;
  assign io_bus.gate_out = io_bus.en ? io_bus.gate_in : '0;
  assign io_bus.mul_full = w_mul_full;
  // Low half wraps silently; the ALU relies on 1*x = x and 0*x = 0 here.
  assign io_bus.mul_out  = w_mul_full[WIDTH-1:0];
  assign io_bus.mul_reg  = r_mul_reg;

  // Product register: clear on reset, load full product on WE, otherwise hold.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mul_reg <= '0;
    end else if (io_bus.we) begin
      r_mul_reg <= w_mul_full;
    end
  end

endmodule

// File: tb/tb_mul_mux_datapath.sv
// Self-checking bench for mul_mux_datapath: directed vector table, register sequences, random vs. model.
// Inputs change on the falling edge; results are sampled 1 time unit after an edge.
// No handshake in the design, so every wait is a fixed number of clock edges.
module tb_mul_mux_datapath;

  localparam int W = 8;

  logic i_clk;
  logic i_rst;
  int   n_tests;
  int   n_fail;

  mul_mux_datapath_if #(.WIDTH(W)) bus ();

  mul_mux_datapath #(.WIDTH(W)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .io_bus (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic         sel;
    logic [7:0]   a;
    logic [7:0]   b;
    logic [7:0]   g;
    logic         en;
    logic [7:0]   ma;
    logic [7:0]   mb;
    logic [7:0]   e_mux;
    logic [7:0]   e_gate;
    logic [7:0]   e_mout;
    logic [15:0]  e_full;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive all inputs just after a falling edge, then let the combinational outputs settle.
  task automatic apply(input logic sel, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] g, input logic en,
                       input logic [7:0] ma, input logic [7:0] mb,
                       input logic we, input logic rst);
    @(negedge i_clk);
    bus.sel     = sel;
    bus.mux_a   = a;
    bus.mux_b   = b;
    bus.gate_in = g;
    bus.en      = en;
    bus.mul_a   = ma;
    bus.mul_b   = mb;
    bus.we      = we;
    i_rst       = rst;
    #1;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Reference: signed product from plain integer arithmetic.
  function automatic logic [15:0] ref_full(input logic [7:0] a, input logic [7:0] b);
    int pa;
    int pb;
    int p;
    pa = (a >= 8'd128) ? int'(a) - 256 : int'(a);
    pb = (b >= 8'd128) ? int'(b) - 256 : int'(b);
    p  = pa * pb;
    return p[15:0];
  endfunction

  initial begin
    logic [15:0] exp_reg;
    logic [15:0] f;
    logic        r_sel, r_en, r_we, r_rst;
    logic [7:0]  r_a, r_b, r_g, r_ma, r_mb;
    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{1'b1, 8'h12, 8'h34, 8'hA5, 1'b1, 8'h01, 8'hFB, 8'h12, 8'hA5, 8'hFB, 16'hFFFB};
    vecs[1] = '{1'b0, 8'h12, 8'h34, 8'hA5, 1'b0, 8'h00, 8'hFB, 8'h34, 8'h00, 8'h00, 16'h0000};
    vecs[2] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 1'b1, 8'h10, 8'h10, 8'hFF, 8'hFF, 8'h00, 16'h0100};
    vecs[3] = '{1'b0, 8'hFF, 8'h00, 8'hFF, 1'b0, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 16'h4000};
    vecs[4] = '{1'b1, 8'h5A, 8'hC3, 8'h3C, 1'b1, 8'h03, 8'hF9, 8'h5A, 8'h3C, 8'hEB, 16'hFFEB};
    vecs[5] = '{1'b0, 8'h5A, 8'hC3, 8'h3C, 1'b0, 8'h7F, 8'h80, 8'hC3, 8'h00, 8'h80, 16'hC080};

    // Reset state; WE held high to confirm reset wins.
    apply(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h05, 8'h06, 1'b1, 1'b1);
    tick();
    tick();
    chk("reset_mulreg", 32'(bus.mul_reg), 32'h0000);

    // Directed combinational table (WE low, register must stay at zero).
    for (int i = 0; i < 6; i++) begin
      apply(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].g, vecs[i].en,
            vecs[i].ma, vecs[i].mb, 1'b0, 1'b0);
      chk("vec_mux",  32'(bus.mux_out),  32'(vecs[i].e_mux));
      chk("vec_gate", 32'(bus.gate_out), 32'(vecs[i].e_gate));
      chk("vec_mout", 32'(bus.mul_out),  32'(vecs[i].e_mout));
      chk("vec_full", 32'(bus.mul_full), 32'(vecs[i].e_full));
    end
    tick();
    chk("hold_zero_we0", 32'(bus.mul_reg), 32'h0000);

    // Load 3 * -7.
    apply(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h03, 8'hF9, 1'b1, 1'b0);
    chk("load_pre_edge", 32'(bus.mul_reg), 32'h0000);
    tick();
    chk("load_3x_m7", 32'(bus.mul_reg), 32'hFFEB);

    // Hold with changed inputs.
    apply(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h05, 8'h05, 1'b0, 1'b0);
    tick();
    chk("hold_ffeb", 32'(bus.mul_reg), 32'hFFEB);

    // Mid-stream reset with WE high; combinational outputs stay live.
    apply(1'b1, 8'h77, 8'h11, 8'h99, 1'b1, 8'h02, 8'h02, 1'b1, 1'b1);
    chk("rst_comb_full", 32'(bus.mul_full), 32'h0004);
    chk("rst_comb_mux",  32'(bus.mux_out),  32'h0077);
    chk("rst_comb_gate", 32'(bus.gate_out), 32'h0099);
    tick();
    chk("rst_clears", 32'(bus.mul_reg), 32'h0000);

    // Reset released but WE low: still zero; then first WE edge loads.
    apply(1'b1, 8'h77, 8'h11, 8'h99, 1'b1, 8'h02, 8'h02, 1'b0, 1'b0);
    tick();
    chk("post_rst_hold", 32'(bus.mul_reg), 32'h0000);
    apply(1'b1, 8'h77, 8'h11, 8'h99, 1'b1, 8'h02, 8'h02, 1'b1, 1'b0);
    tick();
    chk("post_rst_load", 32'(bus.mul_reg), 32'h0004);

    // Random stimulus against the reference model.
    exp_reg = 16'h0004;
    for (int k = 0; k < 300; k++) begin
      r_sel = 1'($urandom);
      r_en  = 1'($urandom);
      r_we  = 1'($urandom);
      r_rst = ($urandom_range(0, 7) == 0);
      r_a   = 8'($urandom);
      r_b   = 8'($urandom);
      r_g   = 8'($urandom);
      r_ma  = 8'($urandom);
      r_mb  = 8'($urandom);
      apply(r_sel, r_a, r_b, r_g, r_en, r_ma, r_mb, r_we, r_rst);
      f = ref_full(r_ma, r_mb);
      chk("rnd_mux",  32'(bus.mux_out),  32'(r_sel ? r_a : r_b));
      chk("rnd_gate", 32'(bus.gate_out), 32'(r_en ? r_g : 8'h00));
      chk("rnd_mout", 32'(bus.mul_out),  32'(f[7:0]));
      chk("rnd_full", 32'(bus.mul_full), 32'(f));
      if (r_rst)
        exp_reg = 16'h0000;
      else if (r_we)
        exp_reg = f;
      tick();
      chk("rnd_reg", 32'(bus.mul_reg), 32'(exp_reg));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
